if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage RV32I core. It owns the PC and issues word fetches to the memory controller. It predicts the next PC for JAL and conditional branches using a 64-entry 2-bit branch history table (BHT), and hands {pc, inst, jmp} to if_id. That payload reaches id_ex as `id_pc`/`jmp_i` two stages later. It redirects on `ex_pre_fail` and trains the BHT from EX branch-resolution results.

---
 rtl/if_fetch_pkg.sv | 30 +++
 rtl/if_fetch_if.sv | 14 +
 rtl/if_fetch_bht.sv | 40 ++++
 rtl/if_fetch.sv | 176 +++++++++++++++++
 tb/tb_if_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds stall-bus encoding, RV32I opcodes and the BHT counter update rule.
package if_fetch_pkg;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [31:0]        inst_addr_t;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Two-bit saturating counter: 00 strongly not-taken .. 11 strongly taken.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch bus between the IF stage (master) and the memory controller (slave).
// Request/address are held by the master until the one-cycle done pulse.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_done_i;
    logic [31:0] mem_inst_i;

    modport master (output mem_req_o, mem_addr_o, input  mem_done_i, mem_inst_i);
    modport slave  (input  mem_req_o, mem_addr_o, output mem_done_i, mem_inst_i);

endinterface

// File: rtl/if_fetch_bht.sv
// Branch history table: array of 2-bit saturating counters, one combinational
// read port and one update port; a same-cycle write is seen by reads next cycle.
module if_fetch_bht
    import if_fetch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            logic [1:0] ctr_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (rst == RST_ENABLE) begin
                    ctr_reg <= 2'b01;
                end else if (rdy && upd_en && (upd_idx == IDX_W'(gi))) begin
                    ctr_reg <= ctr_update(ctr_reg, upd_taken);
                end
            end

            assign ctr_q[gi] = ctr_reg;
        end
    endgenerate

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: owns the PC, issues word fetches, predicts
// JAL/branch targets via the BHT and hands {pc, inst, jmp} to if_id.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int         BHT_IDX_W = 6,
    parameter inst_addr_t RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  stall_bus_t  stall_stmt,
    input  logic        ex_pre_fail,
    input  inst_addr_t  ex_target_i,
    input  logic        ex_br_valid_i,
    input  inst_addr_t  ex_br_pc_i,
    input  logic        ex_br_taken_i,
    if_fetch_if.master  mem,
    output logic        if_valid_o,
    output inst_addr_t  if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_jmp_o,
    output logic        stallreq_o
);

    fetch_state_t state_reg, state_next;
    inst_addr_t   pc_reg, pc_next;
    logic         req_reg, req_next;
    inst_addr_t   addr_reg, addr_next;
    logic         valid_reg, valid_next;
    inst_addr_t   ipc_reg, ipc_next;
    logic [31:0]  inst_reg, inst_next;
    logic         jmp_reg, jmp_next;
    logic         drop_reg, drop_next;

    logic [1:0]   bht_ctr;
    logic [31:0]  j_imm, b_imm;
    logic         pred_taken;
    inst_addr_t   pred_next;

    if_fetch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (addr_reg[BHT_IDX_W+1:2]),
        .rd_ctr    (bht_ctr),
        .upd_en    (ex_br_valid_i),
        .upd_idx   (ex_br_pc_i[BHT_IDX_W+1:2]),
        .upd_taken (ex_br_taken_i)
    );

    logic unused_bits;
    assign unused_bits = ^{ex_br_pc_i[31:BHT_IDX_W+2], ex_br_pc_i[1:0],
                           stall_stmt[STALL_W-1:2], bht_ctr[0]};

    assign j_imm = {{12{mem.mem_inst_i[31]}}, mem.mem_inst_i[19:12], mem.mem_inst_i[20],
                    mem.mem_inst_i[30:21], 1'b0};
    assign b_imm = {{20{mem.mem_inst_i[31]}}, mem.mem_inst_i[7], mem.mem_inst_i[30:25],
                    mem.mem_inst_i[11:8], 1'b0};

    // The outstanding request address is the PC of the instruction being returned.
    always_comb begin
        pred_taken = 1'b0;
        pred_next  = addr_reg + 32'd4;
        case (mem.mem_inst_i[6:0])
            OP_JAL: begin
                pred_taken = 1'b1;
                pred_next  = addr_reg + j_imm;
            end
            OP_BRANCH: begin
                if (bht_ctr[1]) begin
                    pred_taken = 1'b1;
                    pred_next  = addr_reg + b_imm;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        valid_next = valid_reg;
        ipc_next   = ipc_reg;
        inst_next  = inst_reg;
        jmp_next   = jmp_reg;
        drop_next  = drop_reg;

        if (rdy) begin
            if (ex_pre_fail) begin
                pc_next    = ex_target_i;
                valid_next = 1'b0;
                if (state_reg == S_WAIT) begin
                    // An in-flight request must complete; its data is discarded.
                    if (mem.mem_done_i) begin
                        req_next   = 1'b0;
                        drop_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (stall_stmt[0] == NO_STOP) begin
                            req_next   = 1'b1;
                            addr_next  = pc_reg;
                            state_next = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem.mem_done_i) begin
                            req_next = 1'b0;
                            if (drop_reg) begin
                                drop_next  = 1'b0;
                                state_next = S_IDLE;
                            end else begin
                                ipc_next   = addr_reg;
                                inst_next  = mem.mem_inst_i;
                                jmp_next   = pred_taken;
                                pc_next    = pred_next;
                                valid_next = 1'b1;
                                state_next = S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (stall_stmt[1] != STOP) begin
                            valid_next = 1'b0;
                            state_next = S_IDLE;
                        end
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            ipc_reg   <= '0;
            inst_reg  <= '0;
            jmp_reg   <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
            valid_reg <= valid_next;
            ipc_reg   <= ipc_next;
            inst_reg  <= inst_next;
            jmp_reg   <= jmp_next;
            drop_reg  <= drop_next;
        end
    end

    assign mem.mem_req_o  = req_reg;
    assign mem.mem_addr_o = addr_reg;
    assign if_valid_o     = valid_reg;
    assign if_pc_o        = ipc_reg;
    assign if_inst_o      = inst_reg;
    assign if_jmp_o       = jmp_reg;
    assign stallreq_o     = (state_reg != S_HOLD);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory-controller stand-in plus a
// reference model (expected PC, integer BHT counters) driven with $urandom.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    stall_bus_t  stall_stmt;
    logic        ex_pre_fail;
    logic [31:0] ex_target_i;
    logic        ex_br_valid_i;
    logic [31:0] ex_br_pc_i;
    logic        ex_br_taken_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_jmp_o;
    logic        stallreq_o;

    if_fetch_if mem_bus ();

    if_fetch #(.BHT_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .stall_stmt    (stall_stmt),
        .ex_pre_fail   (ex_pre_fail),
        .ex_target_i   (ex_target_i),
        .ex_br_valid_i (ex_br_valid_i),
        .ex_br_pc_i    (ex_br_pc_i),
        .ex_br_taken_i (ex_br_taken_i),
        .mem           (mem_bus),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_jmp_o      (if_jmp_o),
        .stallreq_o    (stallreq_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          bht_m [64];
    logic [31:0] exp_pc;
    bit          rand_bht_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_br_valid_i = 1'b0;
        ex_pre_fail   = 1'b0;
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic bht_upd(input logic [31:0] pc, input bit taken);
        int i;
        i = bidx(pc);
        ex_br_valid_i = 1'b1;
        ex_br_pc_i    = pc;
        ex_br_taken_i = taken;
        if (taken) bht_m[i] = (bht_m[i] >= 3) ? 3 : bht_m[i] + 1;
        else       bht_m[i] = (bht_m[i] <= 0) ? 0 : bht_m[i] - 1;
    endtask

    task automatic drive_bht();
        if (rand_bht_en && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) bht_upd(exp_pc, 1'($urandom_range(0, 1)));
            else bht_upd($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
        end
    endtask

    function automatic logic [31:0] enc_jal(input int imm);
        logic [31:0] i;
        logic [4:0]  rd;
        i  = imm;
        rd = 5'($urandom);
        return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_branch(input int imm);
        logic [31:0] i;
        logic [4:0]  rs1, rs2;
        logic [2:0]  f3;
        i   = imm;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f3  = 3'($urandom);
        return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_other();
        logic [6:0]  ops [7];
        logic [24:0] hi;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b0110111, 7'b0010111, 7'b1100111};
        hi  = 25'($urandom);
        return {hi, ops[$urandom_range(0, 6)]};
    endfunction

    // kind: 0 = non-control, 1 = JAL, 2 = conditional branch
    task automatic fetch_one(input logic [31:0] inst, input int kind, input int imm,
                             input int lat, input int hold, input int idle_stop,
                             input bit redir, input logic [31:0] tgt);
        logic [31:0] exp_next;
        bit          exp_jmp;
        int          w;
        w = 0;
        while (mem_bus.mem_req_o !== 1'b1 && w < 8) begin
            drive_bht();
            step();
            w++;
        end
        check("req_issued", mem_bus.mem_req_o, 1);
        check("req_addr", mem_bus.mem_addr_o, exp_pc);
        for (int k = 1; k < lat; k++) begin
            drive_bht();
            step();
            check("addr_stable", mem_bus.mem_addr_o, exp_pc);
        end
        case (kind)
            1: begin exp_jmp = 1'b1; exp_next = exp_pc + imm; end
            2: begin
                exp_jmp  = (bht_m[bidx(exp_pc)] >= 2);
                exp_next = exp_jmp ? exp_pc + imm : exp_pc + 32'd4;
            end
            default: begin exp_jmp = 1'b0; exp_next = exp_pc + 32'd4; end
        endcase
        mem_bus.mem_done_i = 1'b1;
        mem_bus.mem_inst_i = inst;
        drive_bht();
        step();
        mem_bus.mem_done_i = 1'b0;
        mem_bus.mem_inst_i = $urandom;
        check("if_valid", if_valid_o, 1);
        check("if_pc", if_pc_o, exp_pc);
        check("if_inst", if_inst_o, inst);
        check("if_jmp", if_jmp_o, exp_jmp);
        check("stallreq_hold", stallreq_o, 0);
        check("req_after_done", mem_bus.mem_req_o, 0);
        $display("fetch pc=%h inst=%h kind=%0d jmp=%0d next=%h", exp_pc, inst, kind, exp_jmp, exp_next);
        stall_stmt[1] = (hold > 0 || redir) ? STOP : NO_STOP;
        for (int k = 0; k < hold; k++) begin
            drive_bht();
            step();
            check("hold_valid", if_valid_o, 1);
            check("hold_pc", if_pc_o, exp_pc);
            check("hold_noreq", mem_bus.mem_req_o, 0);
        end
        if (redir) begin
            ex_pre_fail = 1'b1;
            ex_target_i = tgt;
            exp_next    = tgt;
        end else begin
            stall_stmt[1] = NO_STOP;
        end
        stall_stmt[0] = (idle_stop > 0) ? STOP : NO_STOP;
        drive_bht();
        step();
        stall_stmt[1] = NO_STOP;
        check("release_valid", if_valid_o, 0);
        check("release_noreq", mem_bus.mem_req_o, 0);
        check("stallreq_idle", stallreq_o, 1);
        for (int k = 0; k < idle_stop; k++) begin
            drive_bht();
            step();
            check("pc_stop_noreq", mem_bus.mem_req_o, 0);
        end
        stall_stmt[0] = NO_STOP;
        drive_bht();
        step();
        check("next_req", mem_bus.mem_req_o, 1);
        check("next_addr", mem_bus.mem_addr_o, exp_next);
        exp_pc = exp_next;
    endtask

    // Redirect while a request is outstanding; its data arrives d cycles later (0 = same cycle).
    task automatic prefail_wait(input logic [31:0] tgt, input int d);
        logic [31:0] old;
        old = exp_pc;
        check("pf_req_outstanding", mem_bus.mem_req_o, 1);
        ex_pre_fail = 1'b1;
        ex_target_i = tgt;
        if (d == 0) begin
            mem_bus.mem_done_i = 1'b1;
            mem_bus.mem_inst_i = enc_jal(64);
        end
        drive_bht();
        step();
        mem_bus.mem_done_i = 1'b0;
        for (int k = 1; k <= d; k++) begin
            check("pf_req_held", mem_bus.mem_req_o, 1);
            check("pf_addr_held", mem_bus.mem_addr_o, old);
            check("pf_no_valid", if_valid_o, 0);
            if (k == d) begin
                mem_bus.mem_done_i = 1'b1;
                mem_bus.mem_inst_i = enc_jal(64);
            end
            drive_bht();
            step();
            mem_bus.mem_done_i = 1'b0;
        end
        check("pf_discard_valid", if_valid_o, 0);
        check("pf_discard_noreq", mem_bus.mem_req_o, 0);
        drive_bht();
        step();
        check("pf_redir_req", mem_bus.mem_req_o, 1);
        check("pf_redir_addr", mem_bus.mem_addr_o, tgt);
        $display("redirect from %h to %h done_delay=%0d", old, tgt, d);
        exp_pc = tgt;
    endtask

    initial begin
        int kind, imm;
        logic [31:0] inst;

        rst = 1'b0; rdy = 1'b1; stall_stmt = '0;
        ex_pre_fail = 1'b0; ex_target_i = '0;
        ex_br_valid_i = 1'b0; ex_br_pc_i = '0; ex_br_taken_i = 1'b0;
        mem_bus.mem_done_i = 1'b0; mem_bus.mem_inst_i = '0;
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        exp_pc = 32'h0;

        step();
        step();
        check("rst_req", mem_bus.mem_req_o, 0);
        check("rst_addr", mem_bus.mem_addr_o, 0);
        check("rst_valid", if_valid_o, 0);
        check("rst_pc", if_pc_o, 0);
        check("rst_inst", if_inst_o, 0);
        check("rst_jmp", if_jmp_o, 0);
        check("rst_stallreq", stallreq_o, 1);
        rst = 1'b1;
        step();
        check("first_req", mem_bus.mem_req_o, 1);
        check("first_addr", mem_bus.mem_addr_o, 0);

        fetch_one(enc_other(), 0, 0, 3, 0, 0, 1'b0, 0);
        prefail_wait(32'h100, 0);
        fetch_one(enc_jal(32'h20), 1, 32'h20, 2, 0, 0, 1'b0, 0);
        prefail_wait(32'h200, 2);
        fetch_one(enc_other(), 0, 0, 1, 5, 0, 1'b1, 32'h40);

        // Branch at 0x40, offset -8: trained taken, then saturated down.
        fetch_one(enc_branch(-8), 2, -8, 2, 0, 0, 1'b0, 0);
        bht_upd(32'h40, 1'b1); step();
        bht_upd(32'h40, 1'b1); step();
        prefail_wait(32'h40, 1);
        fetch_one(enc_branch(-8), 2, -8, 2, 0, 0, 1'b0, 0);
        check("branch_taken_target", exp_pc, 32'h38);
        for (int k = 0; k < 4; k++) begin bht_upd(32'h40, 1'b0); step(); end
        prefail_wait(32'h40, 0);
        fetch_one(enc_branch(-8), 2, -8, 1, 0, 0, 1'b0, 0);
        bht_upd(32'h40, 1'b1); step();
        prefail_wait(32'h40, 2);
        fetch_one(enc_branch(-8), 2, -8, 1, 0, 0, 1'b0, 0);

        // Address wrap in both directions, with a PC stop in between.
        prefail_wait(32'hFFFF_FFF0, 1);
        fetch_one(enc_jal(32'h20), 1, 32'h20, 1, 0, 0, 1'b0, 0);
        fetch_one(enc_jal(-32), 1, -32, 2, 1, 3, 1'b0, 0);

        // rdy=0 freezes everything, including a redirect request.
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ex_pre_fail = 1'b1;
            ex_target_i = 32'hDEAD_0000;
            step();
            check("frz_req", mem_bus.mem_req_o, 1);
            check("frz_addr", mem_bus.mem_addr_o, exp_pc);
            check("frz_stallreq", stallreq_o, 1);
        end
        rdy = 1'b1;
        fetch_one(enc_other(), 0, 0, 2, 0, 0, 1'b0, 0);

        rand_bht_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                1: begin imm = ($urandom_range(0, 262143) - 131072) * 4; inst = enc_jal(imm); end
                2: begin imm = ($urandom_range(0, 2047) - 1024) * 4; inst = enc_branch(imm); end
                default: begin imm = 0; inst = enc_other(); end
            endcase
            if ($urandom_range(0, 5) == 0) prefail_wait($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
            fetch_one(inst, kind, imm, $urandom_range(1, 4), $urandom_range(0, 2),
                      ($urandom_range(0, 4) == 0) ? 1 : 0,
                      ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC);
        end
        rand_bht_en = 1'b0;

        // Asynchronous reset mid-cycle; BHT must come back to weakly not-taken.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_req", mem_bus.mem_req_o, 0);
        check("arst_addr", mem_bus.mem_addr_o, 0);
        check("arst_valid", if_valid_o, 0);
        check("arst_pc", if_pc_o, 0);
        check("arst_inst", if_inst_o, 0);
        check("arst_stallreq", stallreq_o, 1);
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        exp_pc = 32'h0;
        mem_bus.mem_done_i = 1'b0;
        stall_stmt = '0;
        step();
        rst = 1'b1;
        step();
        fetch_one(enc_branch(-16), 2, -16, 2, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
